// File: rtl/snake_screen_sequencer.sv
// snake_screen_sequencer: frame-synchronous VGA screen selector with blinking, timed win/lose screens
//   CLK, RSTn (async, active-low); Frame_Tick, Ready_Sig, Start_Key, Win_Sig, Lose_Sig in;
//   Start/Game/Win/Lose_RGB[2:0] in; Start/Game/Win/Lose_En, Game_Rst, State[1:0],
//   Red_Sig/Green_Sig/Blue_Sig out.
module snake_screen_sequencer #(
  parameter int HOLD_FRAMES  = 180,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Frame_Tick,
  input  logic       Ready_Sig,
  input  logic       Start_Key,
  input  logic       Win_Sig,
  input  logic       Lose_Sig,
  input  logic [2:0] Start_RGB,
  input  logic [2:0] Game_RGB,
  input  logic [2:0] Win_RGB,
  input  logic [2:0] Lose_RGB,
  output logic       Start_En,
  output logic       Game_En,
  output logic       Win_En,
  output logic       Lose_En,
  output logic       Game_Rst,
  output logic [1:0] State,
  output logic       Red_Sig,
  output logic       Green_Sig,
  output logic       Blue_Sig
);
  typedef enum logic [1:0] {START, PLAY, WIN, LOSE} state_t;
  state_t state, nxt;
  logic key_d, pend_go, pend_win, pend_lose, pend_skip, blank, play_d, game_rst;
  logic [7:0] frame_cnt, blink_cnt;
  logic rise, end_screen, blink_end;
  logic [2:0] src;
  assign rise       = Start_Key & ~key_d;
  assign end_screen = state[1];
  assign blink_end  = blink_cnt == 8'(BLINK_FRAMES - 1);
  // Transitions only on frame boundaries; WIN outranks LOSE when both are pending.
  always_comb begin
    nxt = state;
    if (Frame_Tick)
      case (state)
        START:   nxt = pend_go ? PLAY : START;
        PLAY:    nxt = pend_win ? WIN : pend_lose ? LOSE : PLAY;
        default: nxt = (pend_skip || frame_cnt == 8'(HOLD_FRAMES - 1)) ? START : state;
      endcase
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state     <= START;
      key_d     <= 1'b0;
      pend_go   <= 1'b0;
      pend_win  <= 1'b0;
      pend_lose <= 1'b0;
      pend_skip <= 1'b0;
      frame_cnt <= 8'd0;
      blink_cnt <= 8'd0;
      blank     <= 1'b0;
      play_d    <= 1'b0;
      game_rst  <= 1'b0;
    end else begin
      key_d    <= Start_Key;
      play_d   <= state == PLAY;
      game_rst <= state == PLAY && !play_d;
      state    <= nxt;
      if (nxt != state) begin
        pend_go   <= 1'b0;
        pend_win  <= 1'b0;
        pend_lose <= 1'b0;
        pend_skip <= 1'b0;
        frame_cnt <= 8'd0;
        blink_cnt <= 8'd0;
        blank     <= 1'b0;
      end else begin
        pend_go   <= pend_go   | (state == START & rise);
        pend_win  <= pend_win  | (state == PLAY & Win_Sig);
        pend_lose <= pend_lose | (state == PLAY & Lose_Sig);
        pend_skip <= pend_skip | (end_screen & rise);
        if (Frame_Tick && end_screen) begin
          frame_cnt <= frame_cnt == 8'hFF ? frame_cnt : frame_cnt + 8'd1;
          blink_cnt <= blink_end ? 8'd0 : blink_cnt + 8'd1;
          blank     <= blank ^ blink_end;
        end
      end
    end
  assign State    = state;
  assign Start_En = state == START;
  assign Game_En  = state == PLAY;
  assign Win_En   = state == WIN;
  assign Lose_En  = state == LOSE;
  assign Game_Rst = game_rst;
  assign src = state == START ? Start_RGB : state == PLAY ? Game_RGB : state == WIN ? Win_RGB : Lose_RGB;
  assign {Red_Sig, Green_Sig, Blue_Sig} = (Ready_Sig & ~blank) ? src : 3'b000;
endmodule

// File: tb/tb_snake_screen_sequencer.sv
// tb_snake_screen_sequencer: randomized scoreboard bench for snake_screen_sequencer
module tb_snake_screen_sequencer;
  localparam int HOLD = 6, BLINK = 2;
  logic clk = 0, rstn = 0;
  logic tick = 0, ready = 0, key = 0, win = 0, lose = 0;
  logic [2:0] srgb = 0, grgb = 0, wrgb = 0, lrgb = 0;
  logic s_en, g_en, w_en, l_en, grst, r, g, b;
  logic [1:0] st;
  int compared = 0, mismatched = 0;
  logic [9:0] exp_q[$];
  int m_st, m_fc, m_age;
  bit m_go, m_win, m_lose, m_skip, m_kd;

  snake_screen_sequencer #(.HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) dut (
    .CLK(clk), .RSTn(rstn), .Frame_Tick(tick), .Ready_Sig(ready), .Start_Key(key),
    .Win_Sig(win), .Lose_Sig(lose), .Start_RGB(srgb), .Game_RGB(grgb), .Win_RGB(wrgb),
    .Lose_RGB(lrgb), .Start_En(s_en), .Game_En(g_en), .Win_En(w_en), .Lose_En(l_en),
    .Game_Rst(grst), .State(st), .Red_Sig(r), .Green_Sig(g), .Blue_Sig(b));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = 0; m_fc = 0; m_age = 0;
    m_go = 0; m_win = 0; m_lose = 0; m_skip = 0; m_kd = 0;
  endtask

  // One clock edge of the screen rules, applied to the inputs held during the past cycle.
  task automatic model_step();
    int ns;
    bit rs;
    rs = key && !m_kd;
    m_kd = key;
    ns = m_st;
    if (tick) begin
      if (m_st == 0 && m_go) ns = 1;
      else if (m_st == 1 && m_win) ns = 2;
      else if (m_st == 1 && m_lose) ns = 3;
      else if (m_st >= 2 && (m_skip || m_fc == HOLD - 1)) ns = 0;
    end
    if (ns != m_st) begin
      m_go = 0; m_win = 0; m_lose = 0; m_skip = 0; m_fc = 0; m_age = 0;
      m_st = ns;
    end else begin
      if (m_st == 0 && rs) m_go = 1;
      if (m_st == 1 && win) m_win = 1;
      if (m_st == 1 && lose) m_lose = 1;
      if (m_st >= 2 && rs) m_skip = 1;
      if (m_st >= 2 && tick && m_fc < 255) m_fc++;
      if (m_st == 1 && m_age < 255) m_age++;
    end
  endtask

  // Screen shows its source unless the pixel is invisible or the blink is in its dark half.
  function automatic logic [9:0] expect_out();
    bit blank;
    logic [2:0] src, rgb;
    blank = m_st >= 2 && ((m_fc / BLINK) % 2 == 1);
    src = m_st == 0 ? srgb : m_st == 1 ? grgb : m_st == 2 ? wrgb : lrgb;
    rgb = (ready && !blank) ? src : 3'b000;
    return {2'(m_st), m_st == 0, m_st == 1, m_st == 2, m_st == 3, m_st == 1 && m_age == 1, rgb};
  endfunction

  task automatic drive_random();
    tick  = $urandom_range(0, 4) == 0;
    ready = $urandom_range(0, 3) != 0;
    if ($urandom_range(0, 3) == 0) key = ~key;
    win   = $urandom_range(0, 9) == 0;
    lose  = $urandom_range(0, 7) == 0;
    srgb  = 3'($urandom); grgb = 3'($urandom); wrgb = 3'($urandom); lrgb = 3'($urandom);
  endtask

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      logic [9:0] e, a;
      e = exp_q.pop_front();
      a = {st, s_en, g_en, w_en, l_en, grst, r, g, b};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs t=%0t got st=%0d en=%b grst=%b rgb=%b exp st=%0d en=%b grst=%b rgb=%b",
                 $time, a[9:8], a[7:4], a[3], a[2:0], e[9:8], e[7:4], e[3], e[2:0]);
      end
    end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 drive_random();
    exp_q.push_back(expect_out());
    #1 rstn = 1;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      model_step();
      drive_random();
      if ((m_st == 2 && m_fc == 3 && $urandom_range(0, 1) == 0) || $urandom_range(0, 399) == 0) begin
        rstn = 0;
        model_reset();
        exp_q.push_back(expect_out());
        #2 rstn = 1;
      end else
        exp_q.push_back(expect_out());
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
